// File: rtl/sin_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sin_sched_pkg
// Brief    : Shared FSM state type and width helper for the sine voice scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sin_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Mixing N words of DW bits needs log2(N) guard bits to never overflow.
  function automatic int acc_width(input int n, input int dw);
    return dw + $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sin_phase_bank.sv
`default_nettype none
// ============================================================================
// Module   : sin_phase_bank
// Brief    : Per-voice FCW/phase registers, write port, indexed ROM-address read
//            and the once-per-frame phase advance.
// Revision : 1.0 - initial release
// ============================================================================
module sin_phase_bank
  import sin_sched_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_VOICES)-1:0] wr_voice,
  input  logic [PHASE_WIDTH-1:0]        wr_fcw,
  input  logic [$clog2(NUM_VOICES)-1:0] rd_idx,
  input  logic                          update,
  input  logic [NUM_VOICES-1:0]         en_q,
  output logic [ADDR_WIDTH-1:0]         rd_addr
);

  localparam int c_idx_w = $clog2(NUM_VOICES);

  logic [PHASE_WIDTH-1:0] r_fcw   [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] r_phase [NUM_VOICES];

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    localparam logic [c_idx_w-1:0] c_vid = c_idx_w'(v);

    // The update reads the pre-write FCW, so a write landing on DONE waits a frame.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_fcw[v]   <= '0;
        r_phase[v] <= '0;
      end else begin
        if (wr_en && (wr_voice == c_vid)) begin
          r_fcw[v] <= wr_fcw;
        end
        if (update) begin
          r_phase[v] <= en_q[v] ? (r_phase[v] + r_fcw[v]) : '0;
        end
      end
    end
  end

  assign rd_addr = r_phase[rd_idx][PHASE_WIDTH-1 -: ADDR_WIDTH];

endmodule
`default_nettype wire

// File: rtl/sin_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sin_voice_scheduler
// Brief    : Shares one registered sine ROM among NUM_VOICES DDS voices and emits
//            one mixed sample per sample_tick. Define SIN_SCHED_OVERRUN_EN to add
//            the saturating overrun_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module sin_voice_scheduler
  import sin_sched_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sample_tick,
  input  logic [NUM_VOICES-1:0]         voice_en,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_VOICES)-1:0] wr_voice,
  input  logic [PHASE_WIDTH-1:0]        wr_fcw,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_dout,
  output logic [DATA_WIDTH-1:0]         sample_out,
  output logic                          sample_valid,
`ifdef SIN_SCHED_OVERRUN_EN
  output logic [15:0]                   overrun_cnt,
`endif
  output logic                          busy
);

  localparam int                   c_idx_w    = $clog2(NUM_VOICES);
  localparam int                   c_acc_w    = acc_width(NUM_VOICES, DATA_WIDTH);
  localparam logic [c_idx_w-1:0]   c_last_idx = c_idx_w'(NUM_VOICES - 1);

  state_t                     r_state, w_next_state;
  logic                       w_start, w_issue, w_done, w_busy;
  logic [c_idx_w-1:0]         r_idx;
  logic [NUM_VOICES-1:0]      r_en_q;
  logic                       r_v1, r_v2;
  logic [c_idx_w-1:0]         r_vidx1, r_vidx2;
  logic signed [c_acc_w-1:0]  r_acc, w_term, w_acc_sum, w_scaled;
  logic [ADDR_WIDTH-1:0]      w_rd_addr, r_rom_addr;
  logic [DATA_WIDTH-1:0]      r_sample_out;
  logic                       r_sample_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (sample_tick) w_next_state = ISSUE;
      ISSUE:   if (r_idx == c_last_idx) w_next_state = DRAIN;
      DRAIN:   w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_start = (r_state == IDLE) && sample_tick;
    w_issue = (r_state == ISSUE);
    w_done  = (r_state == DONE);
    w_busy  = (r_state != IDLE);
  end

  sin_phase_bank #(
    .NUM_VOICES  (NUM_VOICES),
    .PHASE_WIDTH (PHASE_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_phase_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_voice (wr_voice),
    .wr_fcw   (wr_fcw),
    .rd_idx   (r_idx),
    .update   (w_done),
    .en_q     (r_en_q),
    .rd_addr  (w_rd_addr)
  );

  // Two-stage tag pipeline: address register plus ROM read latency.
  assign w_term    = (r_v2 && r_en_q[r_vidx2])
                   ? {{c_idx_w{rom_dout[DATA_WIDTH-1]}}, rom_dout} : '0;
  assign w_acc_sum = r_acc + w_term;
  assign w_scaled  = w_acc_sum >>> c_idx_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx          <= '0;
      r_en_q         <= '0;
      r_acc          <= '0;
      r_v1           <= 1'b0;
      r_v2           <= 1'b0;
      r_vidx1        <= '0;
      r_vidx2        <= '0;
      r_rom_addr     <= '0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_v1           <= w_issue;
      r_vidx1        <= r_idx;
      r_v2           <= r_v1;
      r_vidx2        <= r_vidx1;
      r_sample_valid <= w_done;
      if (w_start) begin
        r_en_q <= voice_en;
        r_idx  <= '0;
        r_acc  <= '0;
      end else if (r_v2) begin
        r_acc <= w_acc_sum;
      end
      if (w_issue) begin
        r_idx      <= r_idx + 1'b1;
        r_rom_addr <= w_rd_addr;
      end
      // The last voice's word arrives in DONE, so fold it in on the way out.
      if (w_done) begin
        r_sample_out <= w_scaled[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef SIN_SCHED_OVERRUN_EN
  logic [15:0] r_overrun_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun_cnt <= '0;
    end else if (sample_tick && w_busy && (r_overrun_cnt != 16'hFFFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 16'd1;
    end
  end

  assign overrun_cnt = r_overrun_cnt;
`endif

  assign rom_addr     = r_rom_addr;
  assign sample_out   = r_sample_out;
  assign sample_valid = r_sample_valid;
  assign busy         = w_busy;

endmodule
`default_nettype wire
